// File: rtl/pic8259_pkg.sv
// Shared types and constants for the 8259A control logic.
// MCS80_MODE_EN enables the three-byte MCS-80/85 INTA sequence.
package pic8259_pkg;

   typedef enum logic [2:0] {
      InitIdle,
      InitWaitIcw2,
      InitWaitIcw3,
      InitWaitIcw4,
      InitReady
   } init_state_e;

   typedef enum logic [2:0] {
      AckIdle,
      AckPulse1,
      AckWait2,
      AckPulse2,
      AckWait3,
      AckPulse3
   } ack_state_e;

   localparam int unsigned Icw1Ic4  = 0;
   localparam int unsigned Icw1Sngl = 1;
   localparam int unsigned Icw1Adi  = 2;
   localparam int unsigned Icw4Upm  = 0;
   localparam int unsigned Icw4Aeoi = 1;

   localparam logic [7:0] CallOpcode = 8'hCD;

   // Lowest set bit wins when more than one request is presented.
   function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (onehot[i]) idx = i[2:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/pic8259_icw_regs.sv
// Initialization command word capture: ICW1..ICW4 sequencing FSM and registers.
// Write strobes are levels; each is acted on at its rising edge.
module pic8259_icw_regs
   import pic8259_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       write_icw1,
   input  logic       write_icw2_4,
   output logic       icw1_edge,
   output logic       ready,
   output logic       sngl,
   output logic       adi,
   output logic [2:0] addr,
   output logic [7:0] icw2,
   output logic [7:0] icw3,
   output logic       upm,
   output logic       aeoi
);

   init_state_e state_q, state_d;
   logic        write_icw1_q, write_icw2_4_q;
   logic        icw2_4_edge;
   logic        ic4_q, ic4_d, sngl_q, sngl_d, adi_q, adi_d;
   logic [2:0]  addr_q, addr_d;
   logic [7:0]  icw2_q, icw2_d, icw3_q, icw3_d;
   logic        upm_q, upm_d, aeoi_q, aeoi_d;

   assign icw1_edge   = write_icw1 & ~write_icw1_q;
   assign icw2_4_edge = write_icw2_4 & ~write_icw2_4_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= InitIdle;
         write_icw1_q   <= 1'b0;
         write_icw2_4_q <= 1'b0;
         ic4_q          <= 1'b0;
         sngl_q         <= 1'b0;
         adi_q          <= 1'b0;
         addr_q         <= 3'd0;
         icw2_q         <= 8'd0;
         icw3_q         <= 8'd0;
         upm_q          <= 1'b0;
         aeoi_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         write_icw1_q   <= write_icw1;
         write_icw2_4_q <= write_icw2_4;
         ic4_q          <= ic4_d;
         sngl_q         <= sngl_d;
         adi_q          <= adi_d;
         addr_q         <= addr_d;
         icw2_q         <= icw2_d;
         icw3_q         <= icw3_d;
         upm_q          <= upm_d;
         aeoi_q         <= aeoi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ic4_d   = ic4_q;
      sngl_d  = sngl_q;
      adi_d   = adi_q;
      addr_d  = addr_q;
      icw2_d  = icw2_q;
      icw3_d  = icw3_q;
      upm_d   = upm_q;
      aeoi_d  = aeoi_q;
      if (icw1_edge) begin
         ic4_d   = data[Icw1Ic4];
         sngl_d  = data[Icw1Sngl];
         adi_d   = data[Icw1Adi];
         addr_d  = data[7:5];
         icw3_d  = 8'd0;
         upm_d   = 1'b0;
         aeoi_d  = 1'b0;
         state_d = InitWaitIcw2;
      end else if (icw2_4_edge) begin
         case (state_q)
            InitWaitIcw2: begin
               icw2_d = data;
               if (!sngl_q)    state_d = InitWaitIcw3;
               else if (ic4_q) state_d = InitWaitIcw4;
               else            state_d = InitReady;
            end
            InitWaitIcw3: begin
               icw3_d  = data;
               state_d = ic4_q ? InitWaitIcw4 : InitReady;
            end
            InitWaitIcw4: begin
               upm_d   = data[Icw4Upm];
               aeoi_d  = data[Icw4Aeoi];
               state_d = InitReady;
            end
            default: ;
         endcase
      end
   end

   assign ready = (state_q == InitReady);
   assign sngl  = sngl_q;
   assign adi   = adi_q;
   assign addr  = addr_q;
   assign icw2  = icw2_q;
   assign icw3  = icw3_q;
   assign upm   = upm_q;
   assign aeoi  = aeoi_q;

endmodule

// File: rtl/pic8259_ctrl_logic.sv
// 8259A control logic: INT generation and the INTA sequence (vector, cascade, AEOI).
// Define MCS80_MODE_EN to support the three-pulse MCS-80/85 sequence when uPM=0.
module pic8259_ctrl_logic
   import pic8259_pkg::*;
#(
   parameter int unsigned VEC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sp_en_n,
   input  logic [VEC_W-1:0] internal_data_bus,
   input  logic             write_ICW_1,
   input  logic             write_ICW_2_4,
   input  logic [7:0]       INTERRUPT,
   input  logic             ACK,
   input  logic [2:0]       cascade_in,
   output logic             INT,
   output logic             LATCH,
   output logic             FREEZE,
   output logic [7:0]       CLR_IR,
   output logic [7:0]       EOI,
   output logic             OUT_CTRL_LOGIC_DATA,
   output logic [VEC_W-1:0] CTRL_LOGIC_DATA,
   output logic [2:0]       SLAVE_ID
);

   logic       icw1_edge, ready, sngl, adi, upm, aeoi;
   logic [2:0] addr;
   logic [7:0] icw2, icw3;

   pic8259_icw_regs u_icw_regs (
      .clk          (clk),
      .rst_n        (rst_n),
      .data         (internal_data_bus),
      .write_icw1   (write_ICW_1),
      .write_icw2_4 (write_ICW_2_4),
      .icw1_edge    (icw1_edge),
      .ready        (ready),
      .sngl         (sngl),
      .adi          (adi),
      .addr         (addr),
      .icw2         (icw2),
      .icw3         (icw3),
      .upm          (upm),
      .aeoi         (aeoi)
   );

   ack_state_e ack_state_q, ack_state_d;
   logic       ack_prev_q, ack_fall, ack_rise;
   logic [2:0] level_q, level_d, level_now;
   logic       int_q, int_d, latch_q, latch_d, freeze_q, freeze_d, oe_q, oe_d;
   logic [7:0] clr_ir_q, clr_ir_d, eoi_q, eoi_d, data_q, data_d;
   logic [2:0] slave_id_q, slave_id_d;
   logic       vec_drive, done, mcs80;
   logic [7:0] vector, byte2;

   assign ack_fall  = ack_prev_q & ~ACK;
   assign ack_rise  = ~ack_prev_q & ACK;
   assign level_now = onehot_to_index(INTERRUPT);
   assign vector    = {icw2[7:3], level_q};
   // A master keeps off the bus for cascaded levels; a slave drives only when addressed.
   assign vec_drive = sngl | (sp_en_n ? ~icw3[level_q] : (cascade_in == icw3[2:0]));

`ifdef MCS80_MODE_EN
   assign mcs80 = ~upm;
   assign byte2 = adi ? {addr, level_q, 2'b00} : {addr[2:1], level_q, 3'b000};
`else
   logic unused_mcs80;
   assign mcs80        = 1'b0;
   assign byte2        = vector;
   assign unused_mcs80 = ^{upm, adi, addr};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_state_q <= AckIdle;
         ack_prev_q  <= 1'b1;
         level_q     <= 3'd0;
         int_q       <= 1'b0;
         latch_q     <= 1'b0;
         freeze_q    <= 1'b0;
         oe_q        <= 1'b0;
         clr_ir_q    <= 8'd0;
         eoi_q       <= 8'd0;
         data_q      <= 8'd0;
         slave_id_q  <= 3'd0;
      end else begin
         ack_state_q <= ack_state_d;
         ack_prev_q  <= ACK;
         level_q     <= level_d;
         int_q       <= int_d;
         latch_q     <= latch_d;
         freeze_q    <= freeze_d;
         oe_q        <= oe_d;
         clr_ir_q    <= clr_ir_d;
         eoi_q       <= eoi_d;
         data_q      <= data_d;
         slave_id_q  <= slave_id_d;
      end
   end

   always_comb begin
      ack_state_d = ack_state_q;
      level_d     = level_q;
      latch_d     = 1'b0;
      clr_ir_d    = 8'd0;
      eoi_d       = 8'd0;
      freeze_d    = freeze_q;
      oe_d        = oe_q;
      data_d      = data_q;
      slave_id_d  = slave_id_q;
      done        = 1'b0;
      if (icw1_edge) begin
         ack_state_d = AckIdle;
         freeze_d    = 1'b0;
         oe_d        = 1'b0;
         data_d      = 8'd0;
         slave_id_d  = 3'd0;
      end else if (ready) begin
         case (ack_state_q)
            AckIdle: if (ack_fall) begin
               level_d     = level_now;
               latch_d     = 1'b1;
               clr_ir_d    = 8'd1 << level_now;
               freeze_d    = 1'b1;
               ack_state_d = AckPulse1;
               if (sp_en_n && !sngl && icw3[level_now]) slave_id_d = level_now;
               // CALL opcode always comes from the master (or a lone controller).
               if (mcs80 && (sngl || sp_en_n)) begin
                  oe_d   = 1'b1;
                  data_d = CallOpcode;
               end
            end
            AckPulse1: if (ack_rise) begin
               oe_d        = 1'b0;
               data_d      = 8'd0;
               ack_state_d = AckWait2;
            end
            AckWait2: if (ack_fall) begin
               ack_state_d = AckPulse2;
               if (vec_drive) begin
                  oe_d   = 1'b1;
                  data_d = mcs80 ? byte2 : vector;
               end
            end
            AckPulse2: if (ack_rise) begin
               oe_d   = 1'b0;
               data_d = 8'd0;
               if (mcs80) ack_state_d = AckWait3;
               else       done        = 1'b1;
            end
            AckWait3: if (ack_fall) begin
               ack_state_d = AckPulse3;
               if (vec_drive) begin
                  oe_d   = 1'b1;
                  data_d = icw2;
               end
            end
            AckPulse3: if (ack_rise) begin
               oe_d   = 1'b0;
               data_d = 8'd0;
               done   = 1'b1;
            end
            default: ack_state_d = AckIdle;
         endcase
         if (done) begin
            ack_state_d = AckIdle;
            freeze_d    = 1'b0;
            slave_id_d  = 3'd0;
            if (aeoi) eoi_d = 8'd1 << level_q;
         end
      end
      int_d = ~icw1_edge & ready & (|INTERRUPT) & (ack_state_d == AckIdle);
   end

   assign INT                 = int_q;
   assign LATCH               = latch_q;
   assign FREEZE              = freeze_q;
   assign CLR_IR              = clr_ir_q;
   assign EOI                 = eoi_q;
   assign OUT_CTRL_LOGIC_DATA = oe_q;
   assign CTRL_LOGIC_DATA     = data_q;
   assign SLAVE_ID            = slave_id_q;

endmodule

// File: tb/tb_pic8259_ctrl_logic.sv
// Directed bench for pic8259_ctrl_logic: init, single/master/slave INTA, AEOI, reset.
module tb_pic8259_ctrl_logic;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sp_en_n;
   logic [7:0] internal_data_bus;
   logic       write_ICW_1;
   logic       write_ICW_2_4;
   logic [7:0] INTERRUPT;
   logic       ACK;
   logic [2:0] cascade_in;
   logic       INT, LATCH, FREEZE, OUT_CTRL_LOGIC_DATA;
   logic [7:0] CLR_IR, EOI, CTRL_LOGIC_DATA;
   logic [2:0] SLAVE_ID;

   int tests = 0;
   int fails = 0;

   pic8259_ctrl_logic #(.VEC_W(8)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .sp_en_n             (sp_en_n),
      .internal_data_bus   (internal_data_bus),
      .write_ICW_1         (write_ICW_1),
      .write_ICW_2_4       (write_ICW_2_4),
      .INTERRUPT           (INTERRUPT),
      .ACK                 (ACK),
      .cascade_in          (cascade_in),
      .INT                 (INT),
      .LATCH               (LATCH),
      .FREEZE              (FREEZE),
      .CLR_IR              (CLR_IR),
      .EOI                 (EOI),
      .OUT_CTRL_LOGIC_DATA (OUT_CTRL_LOGIC_DATA),
      .CTRL_LOGIC_DATA     (CTRL_LOGIC_DATA),
      .SLAVE_ID            (SLAVE_ID)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr1(input logic [7:0] d);
      internal_data_bus = d;
      write_ICW_1 = 1'b1;
      tick();
      write_ICW_1 = 1'b0;
      tick();
   endtask

   task automatic wr24(input logic [7:0] d);
      internal_data_bus = d;
      write_ICW_2_4 = 1'b1;
      tick();
      write_ICW_2_4 = 1'b0;
      tick();
   endtask

   task automatic ack_set(input logic v);
      ACK = v;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; sp_en_n = 1'b1; internal_data_bus = 8'h00;
      write_ICW_1 = 1'b0; write_ICW_2_4 = 1'b0;
      INTERRUPT = 8'h00; ACK = 1'b1; cascade_in = 3'd0;
      tick(); tick();
      chk("rst_int", INT, 1'b0);
      chk("rst_freeze", FREEZE, 1'b0);
      chk("rst_data", CTRL_LOGIC_DATA, 8'h00);
      rst_n = 1'b1;
      tick();

      // Master init with an ICW1 restart partway through.
      INTERRUPT = 8'h04;
      wr1(8'h01); wr24(8'hA8);
      wr1(8'h01); wr24(8'hA8); wr24(8'h04);
      chk("restart_wait_icw4_int", INT, 1'b0);
      wr24(8'h03);
      chk("master_ready_int", INT, 1'b1);

      // Cascaded level 2: slave ID on CAS, master stays off the bus, AEOI.
      ack_set(1'b0);
      chk("m_latch", LATCH, 1'b1);
      chk("m_clr_ir", CLR_IR, 8'h04);
      chk("m_int_drop", INT, 1'b0);
      chk("m_slave_id1", SLAVE_ID, 3'd2);
      ack_set(1'b1);
      chk("m_latch_pulse", LATCH, 1'b0);
      ack_set(1'b0);
      chk("m_no_drive", OUT_CTRL_LOGIC_DATA, 1'b0);
      chk("m_slave_id2", SLAVE_ID, 3'd2);
      chk("m_freeze", FREEZE, 1'b1);
      ack_set(1'b1);
      chk("m_eoi", EOI, 8'h04);
      chk("m_freeze_off", FREEZE, 1'b0);
      chk("m_slave_id_off", SLAVE_ID, 3'd0);
      tick();
      chk("m_eoi_pulse", EOI, 8'h00);

      // Single mode, level 3 -> vector 0xAB.
      wr1(8'h03); wr24(8'hA8); wr24(8'h03);
      INTERRUPT = 8'h08;
      tick();
      chk("s_int", INT, 1'b1);
      ack_set(1'b0);
      chk("s_latch", LATCH, 1'b1);
      chk("s_clr_ir", CLR_IR, 8'h08);
      chk("s_int_drop", INT, 1'b0);
      ack_set(1'b1);
      chk("s_clr_ir_pulse", CLR_IR, 8'h00);
      ack_set(1'b0);
      chk("s_oe", OUT_CTRL_LOGIC_DATA, 1'b1);
      chk("s_vector", CTRL_LOGIC_DATA, 8'hAB);
      ack_set(1'b1);
      chk("s_oe_off", OUT_CTRL_LOGIC_DATA, 1'b0);
      chk("s_eoi", EOI, 8'h08);
      tick();
      chk("s_eoi_pulse", EOI, 8'h00);

      // Slave, ID 2, level 1: vector 0xA9 on a match, nothing otherwise.
      sp_en_n = 1'b0; cascade_in = 3'd2;
      wr1(8'h01); wr24(8'hA8); wr24(8'h02); wr24(8'h03);
      INTERRUPT = 8'h02;
      tick();
      chk("sl_int", INT, 1'b1);
      ack_set(1'b0);
      chk("sl_slave_id", SLAVE_ID, 3'd0);
      ack_set(1'b1);
      ack_set(1'b0);
      chk("sl_oe", OUT_CTRL_LOGIC_DATA, 1'b1);
      chk("sl_vector", CTRL_LOGIC_DATA, 8'hA9);
      ack_set(1'b1);
      chk("sl_eoi", EOI, 8'h02);
      cascade_in = 3'd3;
      tick();
      ack_set(1'b0); ack_set(1'b1); ack_set(1'b0);
      chk("sl_nomatch_oe", OUT_CTRL_LOGIC_DATA, 1'b0);
      ack_set(1'b1);
      chk("sl_nomatch_freeze_off", FREEZE, 1'b0);

      // Single mode without AEOI; two requests (lowest wins), request drops mid-sequence.
      sp_en_n = 1'b1;
      wr1(8'h03); wr24(8'hA8); wr24(8'h01);
      INTERRUPT = 8'h0C;
      tick();
      ack_set(1'b0);
      chk("p_clr_ir_lowest", CLR_IR, 8'h04);
      INTERRUPT = 8'h00;
      ack_set(1'b1);
      ack_set(1'b0);
      chk("p_vector_stored", CTRL_LOGIC_DATA, 8'hAA);
      ack_set(1'b1);
      chk("p_no_eoi", EOI, 8'h00);
      chk("p_freeze_off", FREEZE, 1'b0);

      // Reset during the second pulse clears outputs without a clock edge.
      INTERRUPT = 8'h08;
      tick();
      ack_set(1'b0); ack_set(1'b1); ack_set(1'b0);
      chk("r_oe_before", OUT_CTRL_LOGIC_DATA, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("r_oe", OUT_CTRL_LOGIC_DATA, 1'b0);
      chk("r_data", CTRL_LOGIC_DATA, 8'h00);
      chk("r_freeze", FREEZE, 1'b0);
      tick();
      rst_n = 1'b1;
      // ACK still low after reset: the edge must be ignored while not initialised.
      tick(); tick();
      chk("r_not_ready_latch", LATCH, 1'b0);
      chk("r_not_ready_freeze", FREEZE, 1'b0);
      ACK = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
